// File: rtl/fp32_to_sfrac32.sv
// Three-stage IEEE-754 single to signed Q1.31 converter with valid/ready flow control.
// Truncates toward zero, flushes denormals, clamps |x| >= 1.0 and Inf, zeroes NaN.
module fp32_to_sfrac32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat,
    output logic        out_nan
);
    localparam int unsigned W  = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;
    localparam int unsigned MW = 24;
    localparam int unsigned AW = 31;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: unpack and classify
    logic [EW-1:0] c_exp;
    logic [FW-1:0] c_mant;
    logic          c_nan, c_clamp, c_neg_one, c_left;
    logic [2:0]    c_lsh;
    logic [4:0]    c_rsh;
    logic [EW-1:0] c_rdist;
    logic [MW-1:0] c_m;

    always_comb begin
        c_exp     = in_data[30:23];
        c_mant    = in_data[22:0];
        c_nan     = (c_exp == 8'hFF) && (c_mant != '0);
        c_clamp   = !c_nan && (c_exp >= 8'd127);
        c_neg_one = (in_data == 32'hBF80_0000);
        c_left    = (c_exp >= 8'd119);
        c_lsh     = 3'(c_exp - 8'd119);
        c_rdist   = 8'd119 - c_exp;
        c_rsh     = (c_rdist >= 8'd24) ? 5'd24 : 5'(c_rdist);
        c_m       = (c_exp == '0) ? '0 : {1'b1, c_mant};
    end

    logic          v1, s1_sign, s1_nan, s1_clamp, s1_sat, s1_left;
    logic [2:0]    s1_lsh;
    logic [4:0]    s1_rsh;
    logic [MW-1:0] s1_m;

    // Stage 2: align the significand into a 31-bit magnitude
    logic [AW-1:0] c_mag;
    always_comb begin
        c_mag = '0;
        if (s1_left) c_mag = AW'(s1_m) << s1_lsh;
        else         c_mag = AW'(s1_m) >> s1_rsh;
    end

    logic          v2, s2_sign, s2_nan, s2_clamp, s2_sat;
    logic [AW-1:0] s2_mag;

    // Stage 3: apply sign, saturation and NaN handling
    logic [W-1:0] c_res;
    logic [W-1:0] c_umag;
    always_comb begin
        c_umag = W'({1'b0, s2_mag});
        c_res  = s2_sign ? (W'(0) - c_umag) : c_umag;
        if (s2_nan)        c_res = '0;
        else if (s2_clamp) c_res = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    // Valid bits and output registers are reset; payload registers just follow en.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            out_data  <= v2 ? c_res : '0;
            out_sat   <= v2 && !s2_nan && s2_clamp && s2_sat;
            out_nan   <= v2 && s2_nan;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign  <= in_data[31];
            s1_nan   <= c_nan;
            s1_clamp <= c_clamp;
            s1_sat   <= c_clamp && !c_neg_one;
            s1_left  <= c_left;
            s1_lsh   <= c_lsh;
            s1_rsh   <= c_rsh;
            s1_m     <= c_m;
            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_clamp <= s1_clamp;
            s2_sat   <= s1_sat;
            s2_mag   <= c_mag;
        end
    end
endmodule

// File: tb/tb_fp32_to_sfrac32.sv
// Bench for fp32_to_sfrac32: directed and random floats scored against a real-arithmetic model,
// plus backpressure and mid-stream reset scenarios.
module tb_fp32_to_sfrac32;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_nan;

    fp32_to_sfrac32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit lat_chk  = 1'b0;
    logic [33:0] exp_q[$];
    int          acc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference: value of the float in real arithmetic, scaled by 2^31 and truncated.
    // Returns {nan, sat, data}.
    function automatic logic [33:0] model(input logic [31:0] f);
        logic        s;
        int          e;
        real         v;
        int          q;
        logic [31:0] d;
        s = f[31];
        e = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] != 0) return {1'b1, 1'b0, 32'h0};
            return {1'b0, 1'b1, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        if (e == 0) return 34'h0;
        v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        if (v >= 1.0) begin
            if (s) return {1'b0, (v != 1.0), 32'h8000_0000};
            return {1'b0, 1'b1, 32'h7FFF_FFFF};
        end
        q = $rtoi(v * 2147483648.0);
        d = 32'(s ? -q : q);
        return {1'b0, 1'b0, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: transfers are judged at the falling edge, ahead of the edge that completes them.
    always @(negedge clk) begin
        logic [33:0] e;
        int          a;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("data", out_data, e[31:0]);
                    check("sat", {31'b0, out_sat}, {31'b0, e[32]});
                    check("nan", {31'b0, out_nan}, {31'b0, e[33]});
                    if (lat_chk) check("latency", 32'(cyc - a), 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) return;
        end
        check("send_timeout", 32'd1, {31'b0, in_ready});
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] dir_vec[19];
        logic [31:0] bp_vec[6];
        logic [31:0] held;
        logic [31:0] r;
        int          idx;
        int          hold_cnt;
        bit          held_done;

        dir_vec = '{32'h3F00_0000, 32'hBF00_0000, 32'h3F7F_FFFF, 32'h0000_0000, 32'h8000_0000,
                    32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000,
                    32'h7FC0_0000, 32'h0000_0001, 32'h3000_0000, 32'hB000_0000, 32'h2F80_0000,
                    32'hBF7F_FFFF, 32'hFFC0_0001, 32'h8000_0001, 32'hAF80_0000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", {30'b0, out_sat, out_nan}, 32'd0);
        rst = 1'b0;
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed values, back to back, fixed latency
        lat_chk = 1'b1;
        foreach (dir_vec[i]) send(dir_vec[i]);
        in_valid = 1'b0;
        drain();

        // Random stream in [-1, 1)
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(100, 126));
            else                           r[30:23] = 8'($urandom_range(0, 126));
            send(r);
        end
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Backpressure: 5-cycle stall once the first result is presented
        foreach (bp_vec[i]) bp_vec[i] = {1'($urandom), 8'($urandom_range(110, 126)), 23'($urandom)};
        idx = 0; hold_cnt = 0; held_done = 1'b0; held = '0;
        for (int c = 0; c < 100 && (idx < 6 || exp_q.size() != 0); c++) begin
            in_valid = (idx < 6);
            in_data  = (idx < 6) ? bp_vec[idx] : 32'h0;
            if (out_valid && !held_done && hold_cnt == 0) begin
                hold_cnt  = 5;
                held_done = 1'b1;
                held      = out_data;
            end
            out_ready = (hold_cnt == 0);
            @(negedge clk);
            if (hold_cnt > 0) begin
                check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                check("bp_stable", out_data, held);
                hold_cnt--;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_sent", 32'(idx), 32'd6);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) send(32'h3F00_0000 + 32'(i));
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_flags", {30'b0, out_sat, out_nan}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        lat_chk = 1'b1;
        send(32'hBE80_0000);
        in_valid = 1'b0;
        check("new_s1", {31'b0, out_valid}, 32'd0);
        step();
        check("new_s2", {31'b0, out_valid}, 32'd0);
        step();
        check("new_s3", {31'b0, out_valid}, 32'd1);
        check("new_data", out_data, 32'hE000_0000);
        step();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
